pool_window_buffer: RTL and testbench

Streaming 2×2 window former that sits directly upstream of the average-pooling stage. It accepts one feature-map pixel per valid cycle in raster order, map after map, and keeps a line buffer of the last `IFM_SIZE+2` pixels. At every stride-2 window position it presents the four window pixels, together with a one-cycle `pool_enable` strobe, to the pooling adders. It also reports the output-pixel address and the map index, and raises `frame_done` at the end of the last map.

---
 rtl/pool_window_buffer_pkg.sv | 26 ++
 rtl/pool_window_buffer_tap_delay_line.sv | 42 ++++
 rtl/pool_window_buffer.sv | 181 ++++++++++++++++++
 tb/tb_pool_window_buffer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pool_window_buffer_pkg.sv
// Shared definitions for the 2x2 pooling window former and the pooling stage:
// FSM encodings and the derived-size formulas both sides must agree on.
package pool_window_buffer_pkg;

  typedef enum logic [1:0] {
    POOL_WIN_IDLE   = 2'd0,
    POOL_WIN_STREAM = 2'd1,
    POOL_WIN_DONE   = 2'd2
  } pool_win_state_e;

  // Output map side length for a stride-2 window.
  function automatic int ifm_size_next(input int ifm_size, input int kernal_size);
    return (ifm_size - kernal_size) / 2 + 1;
  endfunction

  // Line-buffer depth: one full row plus the window width.
  function automatic int fifo_size(input int ifm_size, input int kernal_size);
    return (kernal_size - 1) * ifm_size + kernal_size;
  endfunction

  // Width of an index that can count to v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pool_window_buffer_tap_delay_line.sv
// Enable-gated shift register exposing every stage; tap 0 holds the newest
// word. Synchronous active-low clear.
module tap_delay_line #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en_i,
  input  logic [DATA_WIDTH-1:0]            data_i,
  output logic [DEPTH-1:0][DATA_WIDTH-1:0] taps_o
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] taps_q, taps_d;

  // NOTE: every variable driven from always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    taps_d = taps_q;
    if (en_i) begin
      taps_d[0] = data_i;
      for (int i = 1; i < DEPTH; i++) begin
        taps_d[i] = taps_q[i-1];
      end
    end
  end

  // NOTE: the storage is cleared on reset on purpose -- downstream must see
  // zeros, never stale pixels from before the reset, in every tap.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/pool_window_buffer.sv
// Streaming 2x2 stride-2 window former feeding the average-pooling adders.
// Raster-order pixels in, four window pixels plus address/map index out.
module pool_window_buffer
  import pool_window_buffer_pkg::*;
#(
  parameter int DATA_WIDTH            = 32,
  parameter int IFM_SIZE              = 14,
  parameter int IFM_DEPTH             = 3,
  parameter int KERNAL_SIZE           = 2,
  parameter int NUMBER_OF_IFM         = IFM_DEPTH,
  parameter int IFM_SIZE_NEXT         = ifm_size_next(IFM_SIZE, KERNAL_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM = clog2_min1(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
  parameter int FIFO_SIZE             = fifo_size(IFM_SIZE, KERNAL_SIZE)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  data_valid,
  input  logic [DATA_WIDTH-1:0]                 data_in,
  output logic                                  pool_enable,
  output logic [DATA_WIDTH-1:0]                 pool_data_out_1,
  output logic [DATA_WIDTH-1:0]                 pool_data_out_2,
  output logic [DATA_WIDTH-1:0]                 pool_data_out_3,
  output logic [DATA_WIDTH-1:0]                 pool_data_out_4,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0]      out_addr,
  output logic [clog2_min1(IFM_DEPTH)-1:0]      ifm_index,
  output logic                                  frame_done
);

  localparam int CNT_W  = clog2_min1(IFM_SIZE);
  localparam int MAP_W  = clog2_min1(NUMBER_OF_IFM);
  localparam int IDX_W  = clog2_min1(IFM_DEPTH);
  localparam int ADDR_W = ADDRESS_SIZE_NEXT_IFM;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(IFM_SIZE - 1);
  localparam logic [MAP_W-1:0]  MAP_LAST   = MAP_W'(NUMBER_OF_IFM - 1);
  localparam logic [CNT_W:0]    WIN_LIMIT  = (CNT_W + 1)'(2 * IFM_SIZE_NEXT);
  localparam logic [ADDR_W-1:0] NEXT_WIDTH = ADDR_W'(IFM_SIZE_NEXT);

  generate
    if (KERNAL_SIZE != 2) begin : g_bad_kernel
      $error("pool_window_buffer supports only KERNAL_SIZE == 2");
    end
    if (IFM_SIZE < 2) begin : g_bad_size
      $error("pool_window_buffer requires IFM_SIZE >= 2");
    end
  endgenerate

  // Line buffer; taps_q[k] holds the pixel accepted k+1 valid cycles ago.
  logic [FIFO_SIZE-1:0][DATA_WIDTH-1:0] taps;
  logic                                 unused_taps;

  tap_delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_SIZE)
  ) u_line (
    .clk    (clk),
    .rst_n  (reset),
    .en_i   (data_valid),
    .data_i (data_in),
    .taps_o (taps)
  );

  assign unused_taps = ^taps;

  pool_win_state_e state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [MAP_W-1:0] map_q, map_d;

  logic                  pool_enable_q, pool_enable_d;
  logic [DATA_WIDTH-1:0] win1_q, win1_d, win2_q, win2_d;
  logic [DATA_WIDTH-1:0] win3_q, win3_d, win4_q, win4_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [IDX_W-1:0]      index_q, index_d;

  logic col_last, row_last, map_last, frame_last, fire;

  assign col_last   = (col_q == CNT_LAST);
  assign row_last   = (row_q == CNT_LAST);
  assign map_last   = (map_q == MAP_LAST);
  assign frame_last = data_valid & col_last & row_last & map_last;

  // Odd row and odd column mark the bottom-right corner of a stride-2 window;
  // the limits drop the trailing row/column of odd-sized maps.
  assign fire = data_valid & row_q[0] & col_q[0]
              & ({1'b0, row_q} < WIN_LIMIT)
              & ({1'b0, col_q} < WIN_LIMIT);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    map_d = map_q;
    if (data_valid) begin
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d = '0;
          map_d = map_last ? '0 : map_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    pool_enable_d = fire;
    win1_d        = win1_q;
    win2_d        = win2_q;
    win3_d        = win3_q;
    win4_d        = win4_q;
    addr_d        = addr_q;
    index_d       = index_q;
    if (fire) begin
      win1_d  = taps[IFM_SIZE];
      win2_d  = taps[IFM_SIZE-1];
      win3_d  = taps[0];
      win4_d  = data_in;
      addr_d  = ADDR_W'(row_q >> 1) * NEXT_WIDTH + ADDR_W'(col_q >> 1);
      index_d = IDX_W'(map_q);
    end
  end

  // Frame FSM: the counters run on their own; the FSM only frames them.
  always_comb begin
    state_d    = state_q;
    frame_done = 1'b0;
    case (state_q)
      POOL_WIN_IDLE: begin
        if (data_valid) state_d = POOL_WIN_STREAM;
      end
      POOL_WIN_STREAM: begin
        if (frame_last) state_d = POOL_WIN_DONE;
      end
      POOL_WIN_DONE: begin
        frame_done = 1'b1;
        state_d    = data_valid ? POOL_WIN_STREAM : POOL_WIN_IDLE;
      end
      default: state_d = POOL_WIN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= POOL_WIN_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      map_q         <= '0;
      pool_enable_q <= 1'b0;
      win1_q        <= '0;
      win2_q        <= '0;
      win3_q        <= '0;
      win4_q        <= '0;
      addr_q        <= '0;
      index_q       <= '0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      map_q         <= map_d;
      pool_enable_q <= pool_enable_d;
      win1_q        <= win1_d;
      win2_q        <= win2_d;
      win3_q        <= win3_d;
      win4_q        <= win4_d;
      addr_q        <= addr_d;
      index_q       <= index_d;
    end
  end

  assign pool_enable     = pool_enable_q;
  assign pool_data_out_1 = win1_q;
  assign pool_data_out_2 = win2_q;
  assign pool_data_out_3 = win3_q;
  assign pool_data_out_4 = win4_q;
  assign out_addr        = addr_q;
  assign ifm_index       = index_q;

endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed bench for pool_window_buffer: three instances (4x4x1, 5x5x1, 4x4x2)
// driven with raster ramps; strobes are logged and compared to the window model.
module tb_pool_window_buffer;

  typedef struct {
    int          cyc;
    logic [31:0] d1, d2, d3, d4;
    int          addr;
    int          idx;
  } win_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  dv = '0;
  logic [31:0] din = '0;
  int          cyc = 0;

  logic        pe_a, pe_b, pe_c, fd_a, fd_b, fd_c;
  logic [31:0] d1_a, d2_a, d3_a, d4_a, d1_b, d2_b, d3_b, d4_b, d1_c, d2_c, d3_c, d4_c;
  logic [1:0]  addr_a, addr_b, addr_c;
  logic [0:0]  idx_a, idx_b, idx_c;

  win_t qa[$], qb[$], qc[$];
  int   fda[$], fdb[$], fdc[$];
  int   acc_cyc [0:63];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool_window_buffer #(.DATA_WIDTH(32), .IFM_SIZE(4), .IFM_DEPTH(1)) dut_a (
    .clk(clk), .reset(reset), .data_valid(dv[0]), .data_in(din),
    .pool_enable(pe_a), .pool_data_out_1(d1_a), .pool_data_out_2(d2_a),
    .pool_data_out_3(d3_a), .pool_data_out_4(d4_a), .out_addr(addr_a),
    .ifm_index(idx_a), .frame_done(fd_a));

  pool_window_buffer #(.DATA_WIDTH(32), .IFM_SIZE(5), .IFM_DEPTH(1)) dut_b (
    .clk(clk), .reset(reset), .data_valid(dv[1]), .data_in(din),
    .pool_enable(pe_b), .pool_data_out_1(d1_b), .pool_data_out_2(d2_b),
    .pool_data_out_3(d3_b), .pool_data_out_4(d4_b), .out_addr(addr_b),
    .ifm_index(idx_b), .frame_done(fd_b));

  pool_window_buffer #(.DATA_WIDTH(32), .IFM_SIZE(4), .IFM_DEPTH(2)) dut_c (
    .clk(clk), .reset(reset), .data_valid(dv[2]), .data_in(din),
    .pool_enable(pe_c), .pool_data_out_1(d1_c), .pool_data_out_2(d2_c),
    .pool_data_out_3(d3_c), .pool_data_out_4(d4_c), .out_addr(addr_c),
    .ifm_index(idx_c), .frame_done(fd_c));

  always @(negedge clk) begin
    win_t w;
    if (pe_a) begin
      w.cyc = cyc; w.d1 = d1_a; w.d2 = d2_a; w.d3 = d3_a; w.d4 = d4_a;
      w.addr = int'(addr_a); w.idx = int'(idx_a);
      qa.push_back(w);
    end
    if (pe_b) begin
      w.cyc = cyc; w.d1 = d1_b; w.d2 = d2_b; w.d3 = d3_b; w.d4 = d4_b;
      w.addr = int'(addr_b); w.idx = int'(idx_b);
      qb.push_back(w);
    end
    if (pe_c) begin
      w.cyc = cyc; w.d1 = d1_c; w.d2 = d2_c; w.d3 = d3_c; w.d4 = d4_c;
      w.addr = int'(addr_c); w.idx = int'(idx_c);
      qc.push_back(w);
    end
    if (fd_a) fda.push_back(cyc);
    if (fd_b) fdb.push_back(cyc);
    if (fd_c) fdc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends base..base+n-1 to instance sel; acc_cyc[off+i] records the edge
  // that accepted pixel i. With stall set, a dead cycle follows every pixel.
  task automatic stream(input int sel, input int n, input int base, input int off, input bit stall);
    for (int i = 0; i < n; i++) begin
      din     = 32'(base + i);
      dv      = '0;
      dv[sel] = 1'b1;
      @(posedge clk);
      #1;
      acc_cyc[off + i] = cyc;
      dv = '0;
      if (stall) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Window k of map m: top-left at row 2*(k/n), col 2*(k%n); completed by the
  // bottom-right pixel, which must have been accepted on the strobe's edge.
  task automatic check_frame(input string tag, input win_t q[$], input int first,
                             input int s, input int n, input int nmaps,
                             input int base, input int off);
    for (int m = 0; m < nmaps; m++) begin
      for (int k = 0; k < n * n; k++) begin
        int j, rel, tl;
        j   = first + m * n * n + k;
        rel = m * s * s + 2 * (k / n) * s + 2 * (k % n);
        tl  = base + rel;
        check($sformatf("%s w%0d present", tag, j), 64'(j < q.size()), 64'd1);
        if (j < q.size()) begin
          check($sformatf("%s w%0d out_1", tag, j), 64'(q[j].d1), 64'(tl));
          check($sformatf("%s w%0d out_2", tag, j), 64'(q[j].d2), 64'(tl + 1));
          check($sformatf("%s w%0d out_3", tag, j), 64'(q[j].d3), 64'(tl + s));
          check($sformatf("%s w%0d out_4", tag, j), 64'(q[j].d4), 64'(tl + s + 1));
          check($sformatf("%s w%0d out_addr", tag, j), 64'(q[j].addr), 64'(k));
          check($sformatf("%s w%0d ifm_index", tag, j), 64'(q[j].idx), 64'(m));
          check($sformatf("%s w%0d latency", tag, j), 64'(q[j].cyc),
                64'(acc_cyc[off + rel + s + 1]));
        end
      end
    end
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, " pool_enable"}, 64'(pe_a), 64'd0);
    check({tag, " out_1"}, 64'(d1_a), 64'd0);
    check({tag, " out_2"}, 64'(d2_a), 64'd0);
    check({tag, " out_3"}, 64'(d3_a), 64'd0);
    check({tag, " out_4"}, 64'(d4_a), 64'd0);
    check({tag, " out_addr"}, 64'(addr_a), 64'd0);
    check({tag, " ifm_index"}, 64'(idx_a), 64'd0);
    check({tag, " frame_done"}, 64'(fd_a), 64'd0);
  endtask

  initial begin
    // Power-on reset.
    idle(2);
    check_a_zero("reset");
    check("reset b pool_enable", 64'(pe_b), 64'd0);
    check("reset c frame_done", 64'(fd_c), 64'd0);
    reset = 1'b1;
    idle(1);

    // 4x4 single map, back-to-back.
    qa.delete(); fda.delete();
    stream(0, 16, 0, 0, 1'b0);
    idle(3);
    check("4x4 strobes", 64'(qa.size()), 64'd4);
    check_frame("4x4", qa, 0, 4, 2, 1, 0, 0);
    check("4x4 frame_done count", 64'(fda.size()), 64'd1);
    if (fda.size() == 1 && qa.size() == 4)
      check("4x4 frame_done cycle", 64'(fda[0]), 64'(qa[3].cyc));

    // Same map with a dead cycle after every pixel.
    qa.delete(); fda.delete();
    stream(0, 16, 0, 0, 1'b1);
    idle(3);
    check("stall strobes", 64'(qa.size()), 64'd4);
    check_frame("stall", qa, 0, 4, 2, 1, 0, 0);
    check("stall frame_done count", 64'(fda.size()), 64'd1);
    check("stall hold out_4", 64'(d4_a), 64'd15);
    check("stall hold out_1", 64'(d1_a), 64'd10);
    check("stall idle pool_enable", 64'(pe_a), 64'd0);

    // 5x5: trailing row and column are consumed without windows.
    stream(1, 25, 0, 0, 1'b0);
    idle(3);
    check("5x5 strobes", 64'(qb.size()), 64'd4);
    check_frame("5x5", qb, 0, 5, 2, 1, 0, 0);
    check("5x5 frame_done count", 64'(fdb.size()), 64'd1);
    if (fdb.size() == 1)
      check("5x5 frame_done cycle", 64'(fdb[0]), 64'(acc_cyc[24]));

    // Two 4x4 maps in one frame.
    stream(2, 32, 0, 0, 1'b0);
    idle(3);
    check("2map strobes", 64'(qc.size()), 64'd8);
    check_frame("2map", qc, 0, 4, 2, 2, 0, 0);
    check("2map frame_done count", 64'(fdc.size()), 64'd1);
    if (fdc.size() == 1 && qc.size() == 8)
      check("2map frame_done cycle", 64'(fdc[0]), 64'(qc[7].cyc));

    // Reset mid-frame after pixel 9, with data_valid high during reset.
    stream(0, 10, 0, 0, 1'b0);
    check("pre-reset out_4", 64'(d4_a), 64'd7);
    reset = 1'b0;
    din   = 32'd77;
    dv    = 3'b001;
    idle(1);
    check_a_zero("mid reset");
    dv = '0;
    idle(1);
    reset = 1'b1;
    idle(1);
    check_a_zero("post reset");
    qa.delete(); fda.delete();
    stream(0, 16, 100, 0, 1'b0);
    idle(3);
    check("restart strobes", 64'(qa.size()), 64'd4);
    check_frame("restart", qa, 0, 4, 2, 1, 100, 0);
    check("restart frame_done count", 64'(fda.size()), 64'd1);

    // Two frames back-to-back; pixel 0 of frame 2 lands in the DONE cycle.
    qa.delete(); fda.delete();
    stream(0, 16, 0, 0, 1'b0);
    stream(0, 16, 200, 16, 1'b0);
    idle(3);
    check("b2b strobes", 64'(qa.size()), 64'd8);
    check_frame("b2b f1", qa, 0, 4, 2, 1, 0, 0);
    check_frame("b2b f2", qa, 4, 4, 2, 1, 200, 16);
    check("b2b frame_done count", 64'(fda.size()), 64'd2);
    if (fda.size() == 2 && qa.size() == 8) begin
      check("b2b frame_done 1 cycle", 64'(fda[0]), 64'(qa[3].cyc));
      check("b2b frame_done 2 cycle", 64'(fda[1]), 64'(qa[7].cyc));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
